// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the sequential memory-access stage: funct3 codes,
// FSM state encoding, access-size decoding.
package mem_stage_lsu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RSP
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W,
        SZ_D
    } acc_size_t;

    // Anything not recognised for the configured XLEN is a full-width access.
    function automatic acc_size_t decode_size(input logic [2:0] f3,
                                              input logic       is_store,
                                              input logic       xlen64);
        acc_size_t full;
        acc_size_t sz;
        full = xlen64 ? SZ_D : SZ_W;
        sz   = full;
        if (is_store) begin
            case (f3)
                F3_SB:   sz = SZ_B;
                F3_SH:   sz = SZ_H;
                F3_SW:   sz = SZ_W;
                default: sz = full;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: sz = SZ_B;
                F3_LH, F3_LHU: sz = SZ_H;
                F3_LW:         sz = SZ_W;
                F3_LWU:        sz = xlen64 ? SZ_W : full;
                default:       sz = full;
            endcase
        end
        return sz;
    endfunction

    function automatic logic load_signed(input logic [2:0] f3);
        return ~f3[2];
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic: alignment check, byte enables, store-data
// shifting and load extraction with sign/zero extension.
module mem_stage_lsu_align
    import mem_stage_lsu_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned BE_W   = XLEN / 8,
    parameter int unsigned OFF_W  = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]   alu_val_i,
    input  logic [XLEN-1:0]   rs2_val_i,
    input  logic [XLEN-1:0]   rdata_i,
    input  logic [2:0]        mem_mode_i,
    input  logic              is_store_i,
    input  logic [OFF_W-1:0]  rsp_off_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [OFF_W-1:0]  off_o,
    output logic [BE_W-1:0]   be_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic              misaligned_o,
    output logic [XLEN-1:0]   load_val_o
);

    acc_size_t         sz;
    logic [ADDR_W-1:0] addr_full;
    logic [BE_W-1:0]   be_base;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   mask;
    logic              sign_bit;
    int unsigned       nbits;

    assign addr_full = ADDR_W'(alu_val_i);
    assign addr_o    = addr_full & ~ADDR_W'(BE_W - 1);
    assign off_o     = alu_val_i[OFF_W-1:0];
    assign wdata_o   = rs2_val_i << {off_o, 3'b000};
    assign be_o      = be_base << off_o;
    // Response lanes use the offset captured when the request was issued.
    assign shifted   = rdata_i >> {rsp_off_i, 3'b000};

    always_comb begin
        sz           = decode_size(mem_mode_i, is_store_i, XLEN == 64);
        be_base      = '0;
        nbits        = XLEN;
        sign_bit     = shifted[XLEN-1];
        misaligned_o = 1'b0;
        case (sz)
            SZ_B: begin
                be_base  = BE_W'(1);
                nbits    = 8;
                sign_bit = shifted[7];
            end
            SZ_H: begin
                be_base      = BE_W'(3);
                nbits        = 16;
                sign_bit     = shifted[15];
                misaligned_o = alu_val_i[0];
            end
            SZ_W: begin
                be_base      = BE_W'(15);
                nbits        = 32;
                sign_bit     = shifted[31];
                misaligned_o = |alu_val_i[1:0];
            end
            default: begin
                be_base      = '1;
                nbits        = XLEN;
                sign_bit     = shifted[XLEN-1];
                misaligned_o = |alu_val_i[2:0];
            end
        endcase
        mask       = (nbits >= XLEN) ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
        load_val_o = shifted & mask;
        if (!is_store_i && load_signed(mem_mode_i) && sign_bit)
            load_val_o = load_val_o | ~mask;
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Sequential memory stage between EXE_MEM and MEM_WB: drives a req/gnt/rvalid
// data port, stalls upstream while a transaction is outstanding.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter  int unsigned XLEN       = XLEN_DEFAULT,
    parameter  int unsigned ADDR_W     = 32,
    parameter  int unsigned REG_ADDR_W = 5,
    localparam int unsigned BE_W       = XLEN / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [XLEN-1:0]       alu_val_i,
    input  logic [XLEN-1:0]       rs2_val_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  rd_we_i,
    input  logic                  mem_re_i,
    input  logic                  mem_we_i,
    input  logic [2:0]            mem_mode_i,
    output logic                  stall_o,
    output logic                  req_o,
    output logic                  we_o,
    output logic [ADDR_W-1:0]     addr_o,
    output logic [XLEN-1:0]       wdata_o,
    output logic [BE_W-1:0]       be_o,
    input  logic                  gnt_i,
    input  logic                  rvalid_i,
    input  logic [XLEN-1:0]       rdata_i,
    output logic                  wb_valid_o,
    output logic [XLEN-1:0]       rd_val_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic                  rd_we_o,
    output logic                  misalign_o,
    output logic [ADDR_W-1:0]     misalign_addr_o
);

    localparam int unsigned OFF_W = $clog2(BE_W);

    lsu_state_t       state;
    logic [OFF_W-1:0] off;
    logic [OFF_W-1:0] off_q;
    logic             misaligned;
    logic [XLEN-1:0]  load_val;
    logic             is_store;
    logic             is_mem;

    assign is_store = mem_we_i;
    assign is_mem   = valid_i & (mem_re_i | mem_we_i);

    mem_stage_lsu_align #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W),
        .BE_W   (BE_W),
        .OFF_W  (OFF_W)
    ) u_align (
        .alu_val_i    (alu_val_i),
        .rs2_val_i    (rs2_val_i),
        .rdata_i      (rdata_i),
        .mem_mode_i   (mem_mode_i),
        .is_store_i   (is_store),
        .rsp_off_i    (off_q),
        .addr_o       (addr_o),
        .off_o        (off),
        .be_o         (be_o),
        .wdata_o      (wdata_o),
        .misaligned_o (misaligned),
        .load_val_o   (load_val)
    );

    // Request and stall are combinational so a same-cycle grant on a store
    // lets the pipeline advance without a bubble.
    always_comb begin
        req_o   = 1'b0;
        stall_o = 1'b0;
        case (state)
            ST_IDLE: begin
                if (is_mem && !misaligned) begin
                    req_o   = 1'b1;
                    stall_o = !(is_store && gnt_i);
                end
            end
            ST_REQ: begin
                req_o   = 1'b1;
                stall_o = !(is_store && gnt_i);
            end
            ST_RSP: stall_o = !rvalid_i;
            default: begin
                req_o   = 1'b0;
                stall_o = 1'b0;
            end
        endcase
    end

    assign we_o = req_o & is_store;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            off_q           <= '0;
            wb_valid_o      <= 1'b0;
            rd_val_o        <= '0;
            rd_addr_o       <= '0;
            rd_we_o         <= 1'b0;
            misalign_o      <= 1'b0;
            misalign_addr_o <= '0;
        end else begin
            wb_valid_o <= 1'b0;
            rd_we_o    <= 1'b0;
            misalign_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!valid_i) begin
                        rd_we_o <= 1'b0;
                    end else if (!is_mem) begin
                        wb_valid_o <= 1'b1;
                        rd_val_o   <= alu_val_i;
                        rd_addr_o  <= rd_addr_i;
                        rd_we_o    <= rd_we_i;
                    end else if (misaligned) begin
                        wb_valid_o      <= 1'b1;
                        rd_addr_o       <= rd_addr_i;
                        misalign_o      <= 1'b1;
                        misalign_addr_o <= ADDR_W'(alu_val_i);
                    end else begin
                        off_q <= off;
                        if (gnt_i && is_store) begin
                            wb_valid_o <= 1'b1;
                            rd_addr_o  <= rd_addr_i;
                        end else if (gnt_i) begin
                            state <= ST_RSP;
                        end else begin
                            state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    off_q <= off;
                    if (gnt_i && is_store) begin
                        wb_valid_o <= 1'b1;
                        rd_addr_o  <= rd_addr_i;
                        state      <= ST_IDLE;
                    end else if (gnt_i) begin
                        state <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rvalid_i) begin
                        wb_valid_o <= 1'b1;
                        rd_val_o   <= load_val;
                        rd_addr_o  <= rd_addr_i;
                        rd_we_o    <= rd_we_i;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu at XLEN=32 and XLEN=64 against a byte-level
// reference model of the memory port and load extension.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        use64;
    logic        valid, re, we, rdwe, gnt, rvalid;
    logic [2:0]  mode;
    logic [63:0] alu, rs2, rdata;
    logic [4:0]  rd;

    logic        stall32, req32, we32, wbv32, rdwe32, mis32;
    logic [31:0] addr32, wdata32, rdval32, misaddr32;
    logic [3:0]  be32;
    logic [4:0]  rdaddr32;
    logic        stall64, req64, we64, wbv64, rdwe64, mis64;
    logic [31:0] addr64, misaddr64;
    logic [63:0] wdata64, rdval64;
    logic [7:0]  be64;
    logic [4:0]  rdaddr64;

    logic        o_stall, o_req, o_we, o_wbv, o_rdwe, o_mis;
    logic [31:0] o_addr, o_misaddr;
    logic [63:0] o_wdata, o_rdval;
    logic [7:0]  o_be;
    logic [4:0]  o_rdaddr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.XLEN(32), .ADDR_W(32), .REG_ADDR_W(5)) u_dut32 (
        .clk(clk), .rst(rst), .valid_i(valid & ~use64), .alu_val_i(alu[31:0]),
        .rs2_val_i(rs2[31:0]), .rd_addr_i(rd), .rd_we_i(rdwe), .mem_re_i(re),
        .mem_we_i(we), .mem_mode_i(mode), .stall_o(stall32), .req_o(req32),
        .we_o(we32), .addr_o(addr32), .wdata_o(wdata32), .be_o(be32),
        .gnt_i(gnt & ~use64), .rvalid_i(rvalid & ~use64), .rdata_i(rdata[31:0]),
        .wb_valid_o(wbv32), .rd_val_o(rdval32), .rd_addr_o(rdaddr32),
        .rd_we_o(rdwe32), .misalign_o(mis32), .misalign_addr_o(misaddr32)
    );

    mem_stage_lsu #(.XLEN(64), .ADDR_W(32), .REG_ADDR_W(5)) u_dut64 (
        .clk(clk), .rst(rst), .valid_i(valid & use64), .alu_val_i(alu),
        .rs2_val_i(rs2), .rd_addr_i(rd), .rd_we_i(rdwe), .mem_re_i(re),
        .mem_we_i(we), .mem_mode_i(mode), .stall_o(stall64), .req_o(req64),
        .we_o(we64), .addr_o(addr64), .wdata_o(wdata64), .be_o(be64),
        .gnt_i(gnt & use64), .rvalid_i(rvalid & use64), .rdata_i(rdata),
        .wb_valid_o(wbv64), .rd_val_o(rdval64), .rd_addr_o(rdaddr64),
        .rd_we_o(rdwe64), .misalign_o(mis64), .misalign_addr_o(misaddr64)
    );

    always_comb begin
        o_stall   = use64 ? stall64 : stall32;
        o_req     = use64 ? req64 : req32;
        o_we      = use64 ? we64 : we32;
        o_wbv     = use64 ? wbv64 : wbv32;
        o_rdwe    = use64 ? rdwe64 : rdwe32;
        o_mis     = use64 ? mis64 : mis32;
        o_addr    = use64 ? addr64 : addr32;
        o_misaddr = use64 ? misaddr64 : misaddr32;
        o_wdata   = use64 ? wdata64 : {32'h0, wdata32};
        o_rdval   = use64 ? rdval64 : {32'h0, rdval32};
        o_be      = use64 ? be64 : {4'h0, be32};
        o_rdaddr  = use64 ? rdaddr64 : rdaddr32;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Access size in bytes from funct3, for a core whose word is xb bytes.
    function automatic int unsigned m_bytes(input logic [2:0] f3, input logic st,
                                            input int unsigned xb);
        if (st) begin
            case (f3)
                3'd0: return 1;
                3'd1: return 2;
                3'd2: return 4;
                default: return xb;
            endcase
        end
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2, 3'd6: return 4;
            default: return xb;
        endcase
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] data, input int unsigned off,
                                           input int unsigned nb, input logic [2:0] f3,
                                           input logic [63:0] xmask);
        logic [63:0] v, m;
        v = (data & xmask) >> (8 * off);
        m = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        v = v & m;
        if (f3 < 3'd4 && v[8 * nb - 1]) v = v | ~m;
        return v & xmask;
    endfunction

    task automatic txn(input logic v, input logic r, input logic w, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] d, input logic [4:0] rdi,
                       input logic rwe, input int gd, input int rvd, input logic [63:0] rsp);
        int unsigned xb;
        int unsigned nb;
        int unsigned off;
        logic [63:0] xmask, am, exp_be, exp_wd, exp_ld;
        logic        mis;
        int          stalls;
        xb     = use64 ? 8 : 4;
        xmask  = use64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        am     = a & xmask;
        nb     = m_bytes(f3, w, xb);
        off    = int'(am % 64'(xb));
        mis    = (r | w) && (am % 64'(nb) != 0);
        exp_be = ((64'd1 << nb) - 64'd1) << off & ((64'd1 << xb) - 64'd1);
        exp_wd = ((d & xmask) << (8 * off)) & xmask;
        exp_ld = m_load(rsp, off, nb, f3, xmask);
        stalls = 0;
        valid = v; re = r; we = w; mode = f3; alu = a; rs2 = d; rd = rdi; rdwe = rwe;
        gnt = 1'b0; rvalid = 1'b0; rdata = {$urandom, $urandom};
        if (!v) begin
            #1;
            chk("idle_req", o_req, 0);
            chk("idle_stall", o_stall, 0);
            @(posedge clk); #1;
            chk("idle_wbv", o_wbv, 0);
            chk("idle_rdwe", o_rdwe, 0);
        end else if (!(r | w) || mis) begin
            #1;
            chk("nomem_req", o_req, 0);
            chk("nomem_stall", o_stall, 0);
            @(posedge clk); #1;
            chk("nomem_wbv", o_wbv, 1);
            chk("nomem_mis", o_mis, 64'(mis));
            if (mis) begin
                chk("mis_rdwe", o_rdwe, 0);
                chk("mis_addr", o_misaddr, am[31:0]);
            end else begin
                chk("alu_rdval", o_rdval, am);
                chk("alu_rdaddr", o_rdaddr, rdi);
                chk("alu_rdwe", o_rdwe, rwe);
            end
        end else begin
            for (int c = 0; c <= gd; c++) begin
                gnt = (c == gd);
                #1;
                chk("req", o_req, 1);
                chk("we", o_we, w);
                chk("addr", o_addr, am[31:0] & ~(xb - 1));
                chk("be", o_be, exp_be);
                if (w) chk("wdata", o_wdata, exp_wd);
                chk("req_stall", o_stall, (c == gd) ? !w : 1);
                if (o_stall) stalls++;
                @(posedge clk); #1;
            end
            gnt = 1'b0;
            if (w) begin
                chk("st_wbv", o_wbv, 1);
                chk("st_rdwe", o_rdwe, 0);
                chk("st_mis", o_mis, 0);
            end else begin
                for (int c = 1; c <= rvd; c++) begin
                    rvalid = (c == rvd);
                    if (rvalid) rdata = rsp;
                    #1;
                    chk("rsp_req", o_req, 0);
                    chk("rsp_stall", o_stall, !rvalid);
                    chk("rsp_wbv", o_wbv, 0);
                    if (o_stall) stalls++;
                    @(posedge clk); #1;
                end
                rvalid = 1'b0;
                chk("ld_wbv", o_wbv, 1);
                chk("ld_rdval", o_rdval, exp_ld);
                chk("ld_rdaddr", o_rdaddr, rdi);
                chk("ld_rdwe", o_rdwe, rwe);
            end
            chk("stall_cycles", 64'(stalls), w ? 64'(gd) : 64'(gd + rvd));
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_wbv", o_wbv, 0);
        chk("rst_rdval", o_rdval, 0);
        chk("rst_rdaddr", o_rdaddr, 0);
        chk("rst_rdwe", o_rdwe, 0);
        chk("rst_mis", o_mis, 0);
        chk("rst_misaddr", o_misaddr, 0);
        chk("rst_req", o_req, 0);
    endtask

    task automatic rand_txn();
        logic        v, r, w;
        logic [63:0] a;
        int          kind;
        v    = ($urandom_range(9, 0) != 0);
        kind = $urandom_range(2, 0);
        r    = (kind == 1);
        w    = (kind == 2);
        a    = {$urandom, $urandom};
        if ($urandom_range(1, 0) == 1) a = a & ~64'h7;
        txn(v, r, w, 3'($urandom_range(7, 0)), a, {$urandom, $urandom},
            5'($urandom), 1'($urandom), $urandom_range(3, 0), $urandom_range(3, 1),
            {$urandom, $urandom});
    endtask

    initial begin
        rst = 1'b1; use64 = 1'b0; valid = 0; re = 0; we = 0; rdwe = 0; gnt = 0; rvalid = 0;
        mode = 3'd0; alu = '0; rs2 = '0; rdata = '0; rd = '0;
        #12;
        chk_reset_vals();
        chk("rst_stall", o_stall, 0);
        use64 = 1'b1; #1;
        chk_reset_vals();
        use64 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed XLEN=32 cases
        txn(1, 0, 0, 3'd0, 64'h1234, 64'h0, 5'd3, 1, 0, 1, 64'h0);
        txn(1, 0, 1, 3'd0, 64'h1003, 64'hAB, 5'd4, 0, 0, 1, 64'h0);
        txn(1, 1, 0, 3'd1, 64'h2002, 64'h0, 5'd5, 1, 2, 3, 64'h8001_0000);
        txn(1, 1, 0, 3'd5, 64'h2002, 64'h0, 5'd6, 1, 2, 3, 64'h8001_0000);
        txn(1, 1, 0, 3'd2, 64'h3001, 64'h0, 5'd7, 1, 0, 1, 64'h0);
        txn(1, 0, 1, 3'd1, 64'h5002, 64'hBEEF_1234, 5'd8, 0, 1, 1, 64'h0);
        txn(1, 1, 0, 3'd0, 64'h6001, 64'h0, 5'd9, 1, 0, 1, 64'h0000_F200);

        // Reset while waiting for read data abandons the load
        valid = 1; re = 1; we = 0; mode = 3'd2; alu = 64'h7000; rd = 5'd10; rdwe = 1; gnt = 1;
        @(posedge clk); #1;
        gnt = 0; #1;
        chk("pre_rst_stall", o_stall, 1);
        rst = 1'b1; valid = 0; re = 0; #1;
        chk_reset_vals();
        chk("rst_rsp_stall", o_stall, 0);
        @(posedge clk); #1;
        rst = 1'b0; rvalid = 1; rdata = 64'h1111_2222; #1;
        chk("orphan_rv_stall", o_stall, 0);
        @(posedge clk); #1;
        rvalid = 0;
        chk("orphan_rv_wbv", o_wbv, 0);
        chk("orphan_rv_rdval", o_rdval, 0);
        gnt = 1; #1;
        chk("orphan_gnt_req", o_req, 0);
        @(posedge clk); #1;
        gnt = 0;
        chk("orphan_gnt_wbv", o_wbv, 0);

        for (int i = 0; i < 150; i++) rand_txn();

        // XLEN=64 cases
        use64 = 1'b1;
        txn(1, 1, 0, 3'd6, 64'h4, 64'h0, 5'd11, 1, 0, 1, 64'hDEAD_BEEF_0000_0000);
        txn(1, 1, 0, 3'd3, 64'h8, 64'h0, 5'd12, 1, 1, 2, 64'h8765_4321_0FED_CBA9);
        txn(1, 0, 1, 3'd3, 64'h10, 64'h0123_4567_89AB_CDEF, 5'd13, 0, 0, 1, 64'h0);
        txn(1, 1, 0, 3'd2, 64'h14, 64'h0, 5'd14, 1, 0, 2, 64'h8000_0000_0000_0000);
        txn(1, 1, 0, 3'd3, 64'h1C, 64'h0, 5'd15, 1, 0, 1, 64'h0);
        for (int i = 0; i < 150; i++) rand_txn();

        valid = 0;
        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised, sequential successor to the combinational memory-access stage.
- Sits between EXE_MEM and MEM_WB.
- Drives a request/grant/response data-memory port with variable latency, generates byte enables and lane shifting, sign/zero-extends loads and detects misaligned accesses.
- Raises a stall to hazard detection while a transaction is outstanding, and registers the result towards writeback.

Parameters:
- XLEN, 32, data/GPR width; 32 or 64 (64 enables LD/LWU/SD).
- ADDR_W, 32, byte address width.
- REG_ADDR_W, 5, GPR index width.
- BE_W, XLEN/8, byte-enable width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- valid_i  in  1  EXE_MEM slot holds a valid instruction
- alu_val_i  in  XLEN  address (mem op) or result (non-mem)
- rs2_val_i  in  XLEN  store data
- rd_addr_i  in  REG_ADDR_W  destination register
- rd_we_i  in  1  destination write enable
- mem_re_i  in  1  load
- mem_we_i  in  1  store
- mem_mode_i  in  3  funct3 size/sign
- stall_o  out  1  hold upstream; inputs stay stable while high
- req_o  out  1  memory request
- we_o  out  1  request is a write
- addr_o  out  ADDR_W  address aligned to BE_W bytes
- wdata_o  out  XLEN  lane-shifted store data
- be_o  out  BE_W  byte enables
- gnt_i  in  1  request accepted
- rvalid_i  in  1  read data valid
- rdata_i  in  XLEN  read data, full word
- wb_valid_o  out  1  MEM_WB slot valid
- rd_val_o  out  XLEN  writeback value
- rd_addr_o  out  REG_ADDR_W  writeback register
- rd_we_o  out  1  writeback enable
- misalign_o  out  1  misaligned access flagged, one-cycle pulse with wb_valid_o
- misalign_addr_o  out  ADDR_W  faulting address

Behaviour:
- Reset: the asynchronous rst forces state=IDLE and clears wb_valid_o, rd_val_o, rd_addr_o, rd_we_o, misalign_o, misalign_addr_o and the internal load-lane register; req_o=0.
- Reset mid-transaction: the transaction is abandoned. rvalid_i and gnt_i arriving in IDLE with no request are ignored.
- FSM states:
  - IDLE
  - REQ: req_o held until gnt_i.
  - RSP: wait for rvalid_i.
- Non-memory op (valid_i, !mem_re_i, !mem_we_i): no stall. Next edge: wb_valid_o=1, rd_val_o=alu_val_i, rd_addr_o/rd_we_o copied.
- valid_i=0: next edge wb_valid_o=0, rd_we_o=0.
- Alignment rules:
  - Halfword: addr[0]=0.
  - Word: addr[1:0]=0.
  - Double (XLEN=64 only): addr[2:0]=0.
- Misaligned access: no request. Next edge: wb_valid_o=1, rd_we_o=0, misalign_o=1, misalign_addr_o=alu_val_i. No stall.
- Memory op in IDLE: req_o asserted combinationally that cycle.
  - Store with gnt_i the same cycle: completes, stall_o=0, next edge wb_valid_o=1 with rd_we_o=0.
  - Store without gnt_i: go to REQ, stall_o=1.
  - Load with gnt_i: go to RSP. Without gnt_i: go to REQ. stall_o=1 in both cases.
- REQ: req_o=1 and request fields held from inputs; stall_o=1. On gnt_i, a store completes (stall_o=0 that cycle) and a load moves to RSP.
- RSP: req_o=0, stall_o=1 until rvalid_i. On rvalid_i, stall_o=0 that cycle; the extracted load value is registered to rd_val_o and wb_valid_o=1 next edge; return to IDLE.
- Minimum load latency is 2 cycles (gnt then rvalid); a grant and rvalid in the same cycle are not supported.
- Memory port fields:
  - addr_o = alu_val_i with low log2(BE_W) bits cleared.
  - off = the low bits of alu_val_i.
  - be_o = {1,3,15,255} for {byte,half,word,double}, shifted left by off.
  - wdata_o = rs2_val_i shifted left by 8*off.
- Load extract: (rdata_i >> 8*off), truncated to the access size, then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU) to XLEN.
- The offset is latched at request time and the stored offset is used in RSP.
- Undefined funct3: treated as a full-XLEN access.

Decomposition:
- Shared package/defines:
  - funct3 codes (LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD)
  - FSM state encoding
  - XLEN default
- Sub-module lsu_align: combinational alignment check, be/wdata generation and load extraction/extension. The FSM and pipeline registers stay in mem_stage_lsu.

Test Plan:
1. Non-mem: valid_i=1, alu_val_i=0x1234 -> stall_o never high; next cycle wb_valid_o=1, rd_val_o=0x1234.
2. SB: addr 0x1003, rs2=0xAB, gnt_i the same cycle -> be_o=4'b1000, wdata_o=0xAB000000, addr_o=0x1000, stall_o=0.
3. LH: addr 0x2002, gnt after 2 cycles, rvalid 3 cycles later with rdata=0x8001_0000 -> rd_val_o=0xFFFF8001. LHU instead gives 0x00008001; stall_o high for 5 cycles.
4. LW at 0x3001 -> no req_o; misalign_o=1, misalign_addr_o=0x3001, rd_we_o=0.
5. rst asserted in RSP, then rvalid_i pulsed -> outputs at reset values; no wb_valid_o produced.
6. XLEN=64, LWU at addr 0x4, rdata=0xDEADBEEF_00000000 -> rd_val_o=0x00000000_DEADBEEF, be_o=0xF0.
